// File: rtl/bypass_fifo_n_if.sv
// bypass_fifo_n_if: enqueue/dequeue handshake bundle for bypass_fifo_n.
// OVERFLOW/UNDERFLOW exist only when BYPASS_FIFO_N_ERR_CHECK_EN is defined.
interface bypass_fifo_n_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);
   logic             ENQ;
   logic [WIDTH-1:0] ENQ_VALUE;
   logic             NOT_FULL;
   logic [CW-1:0]    COUNT;
   logic             CONSUMED_BEFORE;
   logic             CLR_CONSUMED;
   logic             CONSUMED;
   logic             NOT_EMPTY;
   logic [WIDTH-1:0] DEQ_VALUE;
   logic             DEQ;
`ifdef BYPASS_FIFO_N_ERR_CHECK_EN
   logic             OVERFLOW;
   logic             UNDERFLOW;
   modport master (
      output ENQ, ENQ_VALUE, CLR_CONSUMED, DEQ,
      input  NOT_FULL, COUNT, CONSUMED_BEFORE, CONSUMED, NOT_EMPTY, DEQ_VALUE,
      input  OVERFLOW, UNDERFLOW
   );
   modport slave (
      input  ENQ, ENQ_VALUE, CLR_CONSUMED, DEQ,
      output NOT_FULL, COUNT, CONSUMED_BEFORE, CONSUMED, NOT_EMPTY, DEQ_VALUE,
      output OVERFLOW, UNDERFLOW
   );
`else
   modport master (
      output ENQ, ENQ_VALUE, CLR_CONSUMED, DEQ,
      input  NOT_FULL, COUNT, CONSUMED_BEFORE, CONSUMED, NOT_EMPTY, DEQ_VALUE
   );
   modport slave (
      input  ENQ, ENQ_VALUE, CLR_CONSUMED, DEQ,
      output NOT_FULL, COUNT, CONSUMED_BEFORE, CONSUMED, NOT_EMPTY, DEQ_VALUE
   );
`endif
endinterface

// File: rtl/bypass_fifo_n.sv
// bypass_fifo_n: DEPTH-entry FIFO with same-cycle bypass when empty and a per-round consumed flag.
// Define BYPASS_FIFO_N_ERR_CHECK_EN to add sticky OVERFLOW/UNDERFLOW flags.
module bypass_fifo_n #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input logic           CLK,
   input logic           RST,
   bypass_fifo_n_if.slave io
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             consumed_q, consumed_d;
   logic             empty, full, wr, rd;
   // A bypass (empty, ENQ & DEQ) neither writes nor reads; a full ENQ is only taken alongside DEQ.
   always_comb begin
      empty      = count_q == '0;
      full       = count_q == CW'(DEPTH);
      wr         = io.ENQ & ~(empty & io.DEQ) & (~full | io.DEQ);
      rd         = io.DEQ & ~empty;
      head_d     = rd ? (head_q == PW'(DEPTH - 1) ? '0 : head_q + 1'b1) : head_q;
      tail_d     = wr ? (tail_q == PW'(DEPTH - 1) ? '0 : tail_q + 1'b1) : tail_q;
      count_d    = count_q + CW'(wr) - CW'(rd);
      consumed_d = io.CLR_CONSUMED ? 1'b0 : (io.ENQ | consumed_q);
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         consumed_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         consumed_q <= consumed_d;
      end
   end
   always_ff @(posedge CLK) begin
      if (!RST && wr) mem_q[tail_q] <= io.ENQ_VALUE;
   end
   assign io.NOT_FULL        = ~full;
   assign io.NOT_EMPTY       = ~empty | io.ENQ;
   assign io.COUNT           = count_q;
   assign io.DEQ_VALUE       = empty ? io.ENQ_VALUE : mem_q[head_q];
   assign io.CONSUMED_BEFORE = consumed_q;
   assign io.CONSUMED        = io.ENQ | consumed_q;
`ifdef BYPASS_FIFO_N_ERR_CHECK_EN
   logic overflow_q, overflow_d, underflow_q, underflow_d, ovf_evt, unf_evt;
   always_comb begin
      ovf_evt     = io.ENQ & ~io.DEQ & full;
      unf_evt     = io.DEQ & ~io.ENQ & empty;
      overflow_d  = overflow_q | ovf_evt;
      underflow_d = underflow_q | unf_evt;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end
`ifndef SYNTHESIS
   always_ff @(posedge CLK) begin
      if (!RST && ovf_evt) $display("%m: enqueue while full at %0t", $time);
      if (!RST && unf_evt) $display("%m: dequeue while empty at %0t", $time);
   end
`endif
   assign io.OVERFLOW  = overflow_q;
   assign io.UNDERFLOW = underflow_q;
`endif
endmodule

// File: tb/tb_bypass_fifo_n.sv
// tb_bypass_fifo_n: directed vector table, hand sequences and random traffic against a queue model.
module tb_bypass_fifo_n;
   localparam int D = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int total = 0;
   int bad = 0;
   logic       c_rst, c_enq, c_deq, c_clr;
   logic [7:0] c_val;
   logic [7:0] mq[$];
   logic       mflag = 1'b0;
   logic       movf = 1'b0, munf = 1'b0;
   typedef struct {
      logic rst, enq, deq, clr;
      logic [7:0] val;
      logic chk, nf, ne;
      logic [2:0] cnt;
      logic [7:0] dv;
      logic cons, cb;
   } vec_t;
   vec_t tbl[18];
   bypass_fifo_n_if #(.WIDTH(8), .DEPTH(D)) bus ();
   bypass_fifo_n #(.WIDTH(8), .DEPTH(D)) dut (.CLK(clk), .RST(rst), .io(bus));
   always #5 clk = ~clk;
   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask
   task automatic drive(input logic r, e, input logic [7:0] v, input logic d, c);
      c_rst = r; c_enq = e; c_val = v; c_deq = d; c_clr = c;
      rst = r; bus.ENQ = e; bus.ENQ_VALUE = v; bus.DEQ = d; bus.CLR_CONSUMED = c;
   endtask
   task automatic model_check;
      int n = mq.size();
      check("not_full", bus.NOT_FULL, n != D);
      check("not_empty", bus.NOT_EMPTY, n != 0 || c_enq);
      check("count", bus.COUNT, n);
      check("deq_value", bus.DEQ_VALUE, n == 0 ? c_val : mq[0]);
      check("consumed", bus.CONSUMED, c_enq | mflag);
      check("consumed_before", bus.CONSUMED_BEFORE, mflag);
`ifdef BYPASS_FIFO_N_ERR_CHECK_EN
      check("overflow", bus.OVERFLOW, movf);
      check("underflow", bus.UNDERFLOW, munf);
`endif
   endtask
   task automatic model_update;
      int n = mq.size();
      if (c_rst) begin
         mq.delete(); mflag = 0; movf = 0; munf = 0;
      end else begin
         movf |= c_enq & ~c_deq & (n == D);
         munf |= c_deq & ~c_enq & (n == 0);
         if (!(n == 0 && c_enq && c_deq)) begin
            if (c_deq && n > 0) void'(mq.pop_front());
            if (c_enq && (n < D || c_deq)) mq.push_back(c_val);
         end
         mflag = c_clr ? 1'b0 : (c_enq | mflag);
      end
   endtask
   task automatic cyc(input logic r, e, input logic [7:0] v, input logic d, c);
      drive(r, e, v, d, c);
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask
   function automatic vec_t mk(input logic r, e, d, c, input logic [7:0] v, input logic k, nf, ne,
                               input logic [2:0] cnt, input logic [7:0] dv, input logic cons, cb);
      vec_t t;
      t.rst = r; t.enq = e; t.deq = d; t.clr = c; t.val = v; t.chk = k;
      t.nf = nf; t.ne = ne; t.cnt = cnt; t.dv = dv; t.cons = cons; t.cb = cb;
      return t;
   endfunction
   initial begin
      drive(1, 0, 8'h00, 0, 0);
      //           rst enq deq clr val    chk nf ne cnt dv     cons cb
      tbl[0]  = mk(1,  0,  0,  0,  8'h00, 0,  0, 0, 0,  8'h00, 0,   0);
      tbl[1]  = mk(0,  0,  0,  0,  8'h00, 1,  1, 0, 0,  8'h00, 0,   0);
      tbl[2]  = mk(0,  1,  1,  0,  8'h5A, 1,  1, 1, 0,  8'h5A, 1,   0);
      tbl[3]  = mk(0,  0,  0,  0,  8'h00, 1,  1, 0, 0,  8'h00, 1,   1);
      tbl[4]  = mk(0,  0,  0,  1,  8'h00, 1,  1, 0, 0,  8'h00, 1,   1);
      tbl[5]  = mk(0,  1,  0,  0,  8'h01, 1,  1, 1, 0,  8'h01, 1,   0);
      tbl[6]  = mk(0,  1,  0,  0,  8'h02, 1,  1, 1, 1,  8'h01, 1,   1);
      tbl[7]  = mk(0,  1,  0,  0,  8'h03, 1,  1, 1, 2,  8'h01, 1,   1);
      tbl[8]  = mk(0,  1,  0,  0,  8'h04, 1,  1, 1, 3,  8'h01, 1,   1);
      tbl[9]  = mk(0,  0,  0,  0,  8'h00, 1,  0, 1, 4,  8'h01, 1,   1);
      tbl[10] = mk(0,  1,  1,  0,  8'h05, 1,  0, 1, 4,  8'h01, 1,   1);
      tbl[11] = mk(0,  0,  1,  0,  8'h00, 1,  0, 1, 4,  8'h02, 1,   1);
      tbl[12] = mk(0,  0,  1,  0,  8'h00, 1,  1, 1, 3,  8'h03, 1,   1);
      tbl[13] = mk(0,  0,  1,  0,  8'h00, 1,  1, 1, 2,  8'h04, 1,   1);
      tbl[14] = mk(0,  0,  1,  0,  8'h00, 1,  1, 1, 1,  8'h05, 1,   1);
      tbl[15] = mk(0,  0,  0,  0,  8'h00, 1,  1, 0, 0,  8'h00, 1,   1);
      tbl[16] = mk(0,  1,  1,  1,  8'h77, 1,  1, 1, 0,  8'h77, 1,   1);
      tbl[17] = mk(0,  0,  0,  0,  8'h00, 1,  1, 0, 0,  8'h00, 0,   0);
      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].rst, tbl[i].enq, tbl[i].val, tbl[i].deq, tbl[i].clr);
         @(negedge clk);
         if (tbl[i].chk) begin
            check($sformatf("v%0d.not_full", i), bus.NOT_FULL, tbl[i].nf);
            check($sformatf("v%0d.not_empty", i), bus.NOT_EMPTY, tbl[i].ne);
            check($sformatf("v%0d.count", i), bus.COUNT, tbl[i].cnt);
            check($sformatf("v%0d.deq_value", i), bus.DEQ_VALUE, tbl[i].dv);
            check($sformatf("v%0d.consumed", i), bus.CONSUMED, tbl[i].cons);
            check($sformatf("v%0d.consumed_before", i), bus.CONSUMED_BEFORE, tbl[i].cb);
         end
         @(posedge clk);
         model_update();
         #1;
      end
      // reset in the middle of traffic discards held entries
      for (int i = 0; i < 3; i++) cyc(0, 1, 8'(8'hA0 + i), 0, 0);
      check("pre_rst.count", bus.COUNT, 3);
      cyc(1, 0, 8'h00, 0, 0);
      check("post_rst.count", bus.COUNT, 0);
      check("post_rst.not_empty", bus.NOT_EMPTY, 0);
      check("post_rst.not_full", bus.NOT_FULL, 1);
      check("post_rst.consumed_before", bus.CONSUMED_BEFORE, 0);
      // overfill: fifth enqueue is dropped
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 8'(8'hB0 + i), 0, 0);
`ifdef BYPASS_FIFO_N_ERR_CHECK_EN
         if (i == 3) check("ovf_after4", bus.OVERFLOW, 0);
`endif
      end
      check("ovf.count", bus.COUNT, 4);
`ifdef BYPASS_FIFO_N_ERR_CHECK_EN
      check("ovf.flag", bus.OVERFLOW, 1);
      check("ovf.unf_flag", bus.UNDERFLOW, 0);
`endif
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 8'h00, 1, 0);
         @(negedge clk);
         if (i < 4) check($sformatf("drain%0d", i), bus.DEQ_VALUE, 8'(8'hB0 + i));
         model_check();
         @(posedge clk);
         model_update();
         #1;
      end
      check("unf.count", bus.COUNT, 0);
`ifdef BYPASS_FIFO_N_ERR_CHECK_EN
      check("unf.flag", bus.UNDERFLOW, 1);
      check("unf.ovf_flag", bus.OVERFLOW, 1);
`endif
      cyc(1, 0, 8'h00, 0, 0);
`ifdef BYPASS_FIFO_N_ERR_CHECK_EN
      check("err_rst.ovf", bus.OVERFLOW, 0);
      check("err_rst.unf", bus.UNDERFLOW, 0);
`endif
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
             $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
